// File: rtl/spinnaker_fpgas_spi_reg_master_pkg.sv
// Shared frame layout, command codes and FSM encoding for the SPI register master.
package spinnaker_fpgas_spi_reg_master_pkg;

  localparam int CMD_BITS   = 8;
  localparam int ADDR_BITS  = 16;
  localparam int DATA_BITS  = 32;
  localparam int FRAME_BITS = CMD_BITS + ADDR_BITS + DATA_BITS;
  localparam int CNT_BITS   = $clog2(FRAME_BITS + 1);

  localparam logic [CMD_BITS-1:0] CMD_READ  = 8'h00;
  localparam logic [CMD_BITS-1:0] CMD_WRITE = 8'h01;

  // Counter value seen on the rising edge that completes each field.
  localparam logic [CNT_BITS-1:0] CMD_LAST   = CNT_BITS'(CMD_BITS - 1);
  localparam logic [CNT_BITS-1:0] ADDR_LAST  = CNT_BITS'(CMD_BITS + ADDR_BITS - 1);
  localparam logic [CNT_BITS-1:0] FRAME_LAST = CNT_BITS'(FRAME_BITS - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CMD  = 3'd1,
    ADDR = 3'd2,
    DATA = 3'd3,
    DONE = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    OP_NONE  = 2'd0,
    OP_READ  = 2'd1,
    OP_WRITE = 2'd2
  } op_t;

  function automatic op_t decode_cmd(input logic [CMD_BITS-1:0] code);
    op_t res;
    res = OP_NONE;
    if (code == CMD_READ)  res = OP_READ;
    if (code == CMD_WRITE) res = OP_WRITE;
    return res;
  endfunction

endpackage

// File: rtl/spinnaker_fpgas_spi_sync.sv
// Two-flop synchronisers for SCLK/NSS/MOSI plus SCLK and NSS edge detection.
// Edge pulses are one clk wide and lag the pins by two to three cycles.
module spinnaker_fpgas_spi_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic sclk,
  input  logic nss,
  input  logic mosi,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic nss_fall,
  output logic nss_rise,
  output logic mosi_sync
);

  logic [1:0] sclk_sr;
  logic [1:0] nss_sr;
  logic [1:0] mosi_sr;
  logic       sclk_d;
  logic       nss_d;
  logic [1:0] flush_sr;
  logic       nss_armed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sr   <= 2'b00;
      nss_sr    <= 2'b11;
      mosi_sr   <= 2'b00;
      sclk_d    <= 1'b0;
      nss_d     <= 1'b1;
      flush_sr  <= 2'b00;
      nss_armed <= 1'b0;
    end else begin
      sclk_sr  <= {sclk_sr[0], sclk};
      nss_sr   <= {nss_sr[0], nss};
      mosi_sr  <= {mosi_sr[0], mosi};
      sclk_d   <= sclk_sr[1];
      nss_d    <= nss_sr[1];
      flush_sr <= {flush_sr[0], 1'b1};
      // The reset value of the NSS chain is not a real level; a falling edge
      // only counts once NSS has genuinely been seen high after reset.
      if (flush_sr[1] && nss_sr[1])
        nss_armed <= 1'b1;
    end
  end

  assign sclk_rise = sclk_sr[1] & ~sclk_d;
  assign sclk_fall = ~sclk_sr[1] & sclk_d;
  assign nss_fall  = nss_armed & ~nss_sr[1] & nss_d;
  assign nss_rise  = nss_sr[1] & ~nss_d;
  assign mosi_sync = mosi_sr[1];

endmodule

// File: rtl/spinnaker_fpgas_spi_reg_master.sv
// SPI slave bridging 56-bit command/address/data frames onto a register bank port.
// Address drives out one cycle after bit 24 is seen; write strobe one cycle after bit 56.
module spinnaker_fpgas_spi_reg_master
  import spinnaker_fpgas_spi_reg_master_pkg::*;
#(
  parameter int REGA_BITS = 14,
  parameter int REGD_BITS = 32
) (
  input  logic                 CLK_IN,
  input  logic                 RESET_N_IN,
  input  logic                 SPI_SCLK_IN,
  input  logic                 SPI_NSS_IN,
  input  logic                 SPI_MOSI_IN,
  output logic                 SPI_MISO_OUT,
  output logic                 REG_WRITE_OUT,
  output logic [REGA_BITS-1:0] REG_ADDR_OUT,
  output logic [REGD_BITS-1:0] REG_WRITE_DATA_OUT,
  input  logic [REGD_BITS-1:0] REG_READ_DATA_IN
);

  logic sclk_rise;
  logic sclk_fall;
  logic nss_fall;
  logic nss_rise;
  logic mosi_s;

  spinnaker_fpgas_spi_sync u_sync (
    .clk       (CLK_IN),
    .rst_n     (RESET_N_IN),
    .sclk      (SPI_SCLK_IN),
    .nss       (SPI_NSS_IN),
    .mosi      (SPI_MOSI_IN),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall),
    .nss_fall  (nss_fall),
    .nss_rise  (nss_rise),
    .mosi_sync (mosi_s)
  );

  state_t                state;
  op_t                   op;
  logic [CNT_BITS-1:0]   bit_cnt;
  logic [DATA_BITS-1:0]  shift_in;
  logic [DATA_BITS-1:0]  shift_next;
  logic [REGD_BITS-1:0]  miso_sr;
  logic                  load_miso;

  assign shift_next = {shift_in[DATA_BITS-2:0], mosi_s};

  always_ff @(posedge CLK_IN or negedge RESET_N_IN) begin
    if (!RESET_N_IN) begin
      state              <= IDLE;
      op                 <= OP_NONE;
      bit_cnt            <= '0;
      shift_in           <= '0;
      miso_sr            <= '0;
      load_miso          <= 1'b0;
      SPI_MISO_OUT       <= 1'b0;
      REG_WRITE_OUT      <= 1'b0;
      REG_ADDR_OUT       <= '0;
      REG_WRITE_DATA_OUT <= '0;
    end else begin
      REG_WRITE_OUT <= 1'b0;
      load_miso     <= 1'b0;
      // Read data is combinational from REG_ADDR_OUT, so sample it one cycle
      // after the address register has updated.
      if (load_miso)
        miso_sr <= REG_READ_DATA_IN;

      if (nss_rise) begin
        state        <= IDLE;
        bit_cnt      <= '0;
        SPI_MISO_OUT <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            bit_cnt      <= '0;
            SPI_MISO_OUT <= 1'b0;
            if (nss_fall)
              state <= CMD;
          end
          CMD: begin
            if (sclk_rise) begin
              shift_in <= shift_next;
              bit_cnt  <= bit_cnt + 1'b1;
              if (bit_cnt == CMD_LAST) begin
                op    <= decode_cmd(shift_next[CMD_BITS-1:0]);
                state <= (decode_cmd(shift_next[CMD_BITS-1:0]) == OP_NONE) ? DONE : ADDR;
              end
            end
          end
          ADDR: begin
            if (sclk_rise) begin
              shift_in <= shift_next;
              bit_cnt  <= bit_cnt + 1'b1;
              if (bit_cnt == ADDR_LAST) begin
                REG_ADDR_OUT <= shift_next[REGA_BITS-1:0];
                load_miso    <= (op == OP_READ);
                state        <= DATA;
              end
            end
          end
          DATA: begin
            if (sclk_rise) begin
              shift_in <= shift_next;
              bit_cnt  <= bit_cnt + 1'b1;
              if (bit_cnt == FRAME_LAST) begin
                state        <= DONE;
                SPI_MISO_OUT <= 1'b0;
                if (op == OP_WRITE) begin
                  REG_WRITE_DATA_OUT <= shift_next[REGD_BITS-1:0];
                  REG_WRITE_OUT      <= 1'b1;
                end
              end
            end else if (sclk_fall && op == OP_READ) begin
              SPI_MISO_OUT <= miso_sr[REGD_BITS-1];
              miso_sr      <= miso_sr << 1;
            end
          end
          DONE: begin
            SPI_MISO_OUT <= 1'b0;
          end
          default: begin
            state        <= IDLE;
            SPI_MISO_OUT <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spinnaker_fpgas_spi_reg_master.sv
// Scoreboard bench: stimulus queues expected write strobes and MISO words,
// independent monitors compare them as the DUT produces them.
module tb_spinnaker_fpgas_spi_reg_master;

  logic        clk_in   = 1'b0;
  logic        reset_n  = 1'b0;
  logic        spi_sclk = 1'b0;
  logic        spi_nss  = 1'b1;
  logic        spi_mosi = 1'b0;
  logic        spi_miso;
  logic        reg_write;
  logic [13:0] reg_addr;
  logic [31:0] reg_wdata;
  logic [31:0] reg_rdata;

  int checks = 0;
  int passes = 0;
  int pulses = 0;

  logic [45:0] wr_q[$];
  logic [55:0] miso_q[$];

  always #5 clk_in = ~clk_in;

  // Register bank model: read data is combinational from the address.
  assign reg_rdata = (reg_addr == 14'd0) ? 32'h12345678 : {16'hA5C3, 2'b00, reg_addr};

  spinnaker_fpgas_spi_reg_master #(.REGA_BITS(14), .REGD_BITS(32)) dut (
    .CLK_IN             (clk_in),
    .RESET_N_IN         (reset_n),
    .SPI_SCLK_IN        (spi_sclk),
    .SPI_NSS_IN         (spi_nss),
    .SPI_MOSI_IN        (spi_mosi),
    .SPI_MISO_OUT       (spi_miso),
    .REG_WRITE_OUT      (reg_write),
    .REG_ADDR_OUT       (reg_addr),
    .REG_WRITE_DATA_OUT (reg_wdata),
    .REG_READ_DATA_IN   (reg_rdata)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
  endtask

  // Write-strobe monitor
  logic        prev_wr = 1'b0;
  logic [45:0] wr_exp;
  always @(negedge clk_in) begin
    if (reg_write === 1'b1) begin
      pulses++;
      chk("wr_single_cycle", {63'd0, prev_wr}, 64'd0);
      if (wr_q.size() == 0) begin
        checks++;
        $display("FAIL wr_unexpected: got strobe addr 0x%0h data 0x%0h, expected no strobe", reg_addr, reg_wdata);
      end else begin
        wr_exp = wr_q.pop_front();
        chk("wr_addr", {50'd0, reg_addr}, {50'd0, wr_exp[45:32]});
        chk("wr_data", {32'd0, reg_wdata}, {32'd0, wr_exp[31:0]});
      end
    end
    prev_wr = reg_write;
  end

  // MISO monitor: master samples MISO on each SCLK rising edge within a frame
  logic [55:0] miso_cap = '0;
  int          miso_cnt = 0;
  logic [55:0] miso_exp;
  always @(posedge spi_sclk or posedge spi_nss) begin
    if (spi_nss) begin
      if (miso_cnt > 0) begin
        if (miso_q.size() == 0) begin
          checks++;
          $display("FAIL miso_frame: got frame of %0d bits, expected none queued", miso_cnt);
        end else begin
          miso_exp = miso_q.pop_front();
          chk("miso_bits", {8'd0, miso_cap}, {8'd0, miso_exp >> (56 - miso_cnt)});
        end
      end
      miso_cnt = 0;
      miso_cap = '0;
    end else begin
      miso_cap = {miso_cap[54:0], spi_miso};
      miso_cnt++;
    end
  end

  task automatic spi_frame(input logic [7:0] cmd, input logic [15:0] addr, input logic [31:0] data,
                           input int nbits, input int half, input int rst_at, input int gap);
    logic [55:0] w;
    w = {cmd, addr, data};
    spi_nss = 1'b0;
    repeat (2) @(negedge clk_in);
    for (int i = 0; i < nbits; i++) begin
      if (i == rst_at) begin
        reset_n = 1'b0;
        #1;
        chk("midrst_write", {63'd0, reg_write}, 64'd0);
        chk("midrst_addr", {50'd0, reg_addr}, 64'd0);
        chk("midrst_wdata", {32'd0, reg_wdata}, 64'd0);
        chk("midrst_miso", {63'd0, spi_miso}, 64'd0);
        repeat (3) @(negedge clk_in);
        reset_n = 1'b1;
      end
      spi_mosi = w[55-i];
      spi_sclk = 1'b0;
      repeat (half) @(negedge clk_in);
      spi_sclk = 1'b1;
      repeat (half) @(negedge clk_in);
    end
    spi_sclk = 1'b0;
    repeat (half) @(negedge clk_in);
    spi_nss  = 1'b1;
    spi_mosi = 1'b0;
    repeat (gap) @(negedge clk_in);
  endtask

  initial begin
    repeat (3) @(negedge clk_in);
    #1;
    chk("rst_write", {63'd0, reg_write}, 64'd0);
    chk("rst_addr", {50'd0, reg_addr}, 64'd0);
    chk("rst_wdata", {32'd0, reg_wdata}, 64'd0);
    chk("rst_miso", {63'd0, spi_miso}, 64'd0);
    @(negedge clk_in);
    reset_n = 1'b1;
    repeat (5) @(negedge clk_in);

    // Write 0xDEADBEEF to 0x0002
    wr_q.push_back({14'h0002, 32'hDEADBEEF});
    miso_q.push_back(56'd0);
    spi_frame(8'h01, 16'h0002, 32'hDEADBEEF, 56, 4, -1, 10);
    chk("w1_addr", {50'd0, reg_addr}, 64'h0002);
    chk("w1_wdata", {32'd0, reg_wdata}, 64'hDEADBEEF);

    // Read 0x0000 -> 0x12345678 on MISO
    miso_q.push_back({24'd0, 32'h12345678});
    spi_frame(8'h00, 16'h0000, 32'h00000000, 56, 4, -1, 10);
    chk("r1_addr", {50'd0, reg_addr}, 64'h0000);
    chk("r1_wdata_held", {32'd0, reg_wdata}, 64'hDEADBEEF);

    // Read 0x0005 -> 0xA5C30005, MOSI data bits set (ignored)
    miso_q.push_back({24'd0, 32'hA5C30005});
    spi_frame(8'h00, 16'h0005, 32'hFFFFFFFF, 56, 4, -1, 10);

    // Write aborted after 40 bits
    miso_q.push_back(56'd0);
    spi_frame(8'h01, 16'h0010, 32'h55AA55AA, 40, 4, -1, 10);
    chk("abort_wdata", {32'd0, reg_wdata}, 64'hDEADBEEF);
    chk("abort_addr", {50'd0, reg_addr}, 64'h0010);

    // Full write; upper address bits beyond REGA_BITS ignored
    wr_q.push_back({14'h0003, 32'h0BADF00D});
    miso_q.push_back(56'd0);
    spi_frame(8'h01, 16'hC003, 32'h0BADF00D, 56, 4, -1, 10);
    chk("w2_addr", {50'd0, reg_addr}, 64'h0003);

    // Invalid command
    miso_q.push_back(56'd0);
    spi_frame(8'h80, 16'h1234, 32'hFFFFFFFF, 56, 4, -1, 10);
    chk("inv_addr", {50'd0, reg_addr}, 64'h0003);
    chk("inv_wdata", {32'd0, reg_wdata}, 64'h0BADF00D);

    // Reset at bit 30 of a write; remaining bits must be ignored
    miso_q.push_back(56'd0);
    spi_frame(8'h01, 16'h0021, 32'h13579BDF, 56, 4, 30, 10);
    chk("postrst_addr", {50'd0, reg_addr}, 64'h0000);
    chk("postrst_wdata", {32'd0, reg_wdata}, 64'h0000);

    // Back-to-back writes, NSS high 4 cycles, SCLK period 8 cycles
    wr_q.push_back({14'h0007, 32'h11111111});
    miso_q.push_back(56'd0);
    wr_q.push_back({14'h3FFF, 32'hFEDCBA98});
    miso_q.push_back(56'd0);
    spi_frame(8'h01, 16'h0007, 32'h11111111, 56, 4, -1, 4);
    spi_frame(8'h01, 16'h3FFF, 32'hFEDCBA98, 56, 4, -1, 10);
    chk("b2b_addr", {50'd0, reg_addr}, 64'h3FFF);

    // Slower SCLK read of 0x0009
    miso_q.push_back({24'd0, 32'hA5C30009});
    spi_frame(8'h00, 16'h0009, 32'h00000000, 56, 7, -1, 10);
    chk("r3_wdata_held", {32'd0, reg_wdata}, 64'hFEDCBA98);

    repeat (20) @(negedge clk_in);
    chk("wr_q_drained", 64'(wr_q.size()), 64'd0);
    chk("miso_q_drained", 64'(miso_q.size()), 64'd0);
    chk("pulse_count", 64'(pulses), 64'd4);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
